within_monitor: RTL

Synthesizable run-time checker for the sequence property `A |=> (B[*3] within C[*]) ##1 D`, the consuming end of the trace-sequencer stimulus used in the SVA regression. It samples A/B/C/D once per clock and tracks one attempt at a time. Each attempt ends with a registered pass or fail pulse plus a failure code. Saturating counters make the results observable to formal and simulation benches without SVA support.

---
 rtl/within_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/within_monitor.sv
// rtl/within_monitor.sv - run-time checker for A |=> (B[*3] within C[*]) ##1 D
//
// Tracks one attempt at a time. Each attempt ends with a registered one-cycle
// pass or fail pulse; fail_code says why it failed. Saturating counters record
// passes, fails and triggers dropped while an attempt was already running.
//
// Ports:
//   clock              sole clock, rising-edge sampling
//   resetn             asynchronous active-low reset
//   a, b, c, d         trigger, repeated element, enclosing window, terminator
//   busy               an attempt is in progress
//   pass / fail        one-cycle result pulses (never together)
//   fail_code          1 = C dropped before B[*3], 2 = C dropped after, no D,
//                      3 = timeout; 0 whenever fail is low
//   pass_count, fail_count, drop_count   saturating event counters

module within_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int LEN_W = CNT_W + 8;
  // A TIMEOUT the saturating length counter can never reach is treated as off.
  localparam bit TIMEOUT_EN = (TIMEOUT > 0) &&
                              (longint'(TIMEOUT) <= (longint'(1) << LEN_W));
  localparam logic [LEN_W:0] TIMEOUT_V = TIMEOUT_EN ? (LEN_W+1)'(TIMEOUT) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_b_cnt, w_b_cnt_nxt;
  logic             r_found, w_found_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;

  logic             r_pass, r_fail;
  logic [1:0]       r_fail_code;
  logic [CNT_W-1:0] r_pass_count, r_fail_count, r_drop_count;

  logic             w_pass, w_fail, w_drop, w_term;
  logic [1:0]       w_fail_code;
  logic [LEN_W:0]   w_len_plus1;
  logic             w_timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign w_len_plus1   = {1'b0, r_len} + (LEN_W+1)'(1);
  assign w_timeout_hit = TIMEOUT_EN && (w_len_plus1 == TIMEOUT_V);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_b_cnt <= 2'd0;
      r_found <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      r_found <= w_found_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_cnt_nxt = r_b_cnt;
    w_found_nxt = r_found;
    w_len_nxt   = r_len;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = 2'd0;
    w_drop      = 1'b0;
    w_term      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (a) begin
          w_state_nxt = S_RUN;
          w_b_cnt_nxt = 2'd0;
          w_found_nxt = 1'b0;
          w_len_nxt   = '0;
        end
      end

      S_RUN: begin
        // found is last cycle's view, so D in the completing cycle is too early.
        if (r_found && d) begin
          w_pass = 1'b1;
          w_term = 1'b1;
        end else if (c) begin
          if (b) begin
            w_b_cnt_nxt = (r_b_cnt == 2'd3) ? 2'd3 : r_b_cnt + 2'd1;
          end else begin
            w_b_cnt_nxt = 2'd0;
          end
          w_found_nxt = r_found | (w_b_cnt_nxt == 2'd3);
          w_len_nxt   = (r_len == '1) ? r_len : r_len + LEN_W'(1);
          if (w_timeout_hit) begin
            w_fail      = 1'b1;
            w_fail_code = 2'd3;
            w_term      = 1'b1;
          end
        end else begin
          w_fail      = 1'b1;
          w_fail_code = r_found ? 2'd2 : 2'd1;
          w_term      = 1'b1;
        end

        // A trigger in the terminating cycle restarts at once; otherwise it
        // is a drop.
        if (w_term) begin
          w_state_nxt = a ? S_RUN : S_IDLE;
          w_b_cnt_nxt = 2'd0;
          w_found_nxt = 1'b0;
          w_len_nxt   = '0;
        end else if (a) begin
          w_drop = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_code  <= 2'd0;
      r_pass_count <= '0;
      r_fail_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_pass      <= w_pass;
      r_fail      <= w_fail;
      r_fail_code <= w_fail_code;
      if (w_pass) r_pass_count <= sat_inc(r_pass_count);
      if (w_fail) r_fail_count <= sat_inc(r_fail_count);
      if (w_drop) r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign busy       = (r_state == S_RUN);
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_code  = r_fail_code;
  assign pass_count = r_pass_count;
  assign fail_count = r_fail_count;
  assign drop_count = r_drop_count;

endmodule
